// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC, in-order imem requests, predictor steering, redirect flush and IF/ID queue.
// Define IF_BYPASS_EN to present a response to an empty queue on id_* in the same cycle.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pred_instr,
  output logic [31:0] pred_pc,
  input  logic [31:0] pre_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pred_pc
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  logic [31:0] fetch_pc;
  logic [31:0] ifq [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic [31:0] q_instr [QDEPTH];
  logic [31:0] q_pred [QDEPTH];
  logic [AW-1:0] ifq_wr, ifq_rd, q_hd, q_tl;
  logic [CW-1:0] outstanding, drop_cnt, qcount, out_next;
  logic acc, take, taken, bypass, q_deq, enq;
  // outstanding + queued never exceeds QDEPTH, so the queue cannot overflow
  assign imem_req_valid = !reset && !redirect_valid &&
                          ({1'b0, outstanding} + {1'b0, qcount} < (CW+1)'(QDEPTH));
  assign imem_req_addr = fetch_pc & ~32'h3;
  assign acc = imem_req_valid && imem_req_ready;
  assign take = !reset && imem_rsp_valid && drop_cnt == '0;
  assign pred_instr = imem_rsp_data;
  assign pred_pc = ifq[ifq_rd];
  assign taken = take && pre_pc != pred_pc + 32'd4;
  assign out_next = outstanding + CW'(acc) - CW'(imem_rsp_valid);
`ifdef IF_BYPASS_EN
  assign bypass = take && qcount == '0;
`else
  assign bypass = 1'b0;
`endif
  assign id_valid = qcount != '0 || bypass;
  assign id_pc = bypass ? pred_pc : q_pc[q_hd];
  assign id_instr = bypass ? imem_rsp_data : q_instr[q_hd];
  assign id_pred_pc = bypass ? pre_pc : q_pred[q_hd];
  assign q_deq = qcount != '0 && id_ready;
  assign enq = take && !redirect_valid && !(bypass && id_ready);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      ifq_wr <= '0;
      ifq_rd <= '0;
      q_hd <= '0;
      q_tl <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      qcount <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ifq[i] <= '0;
        q_pc[i] <= '0;
        q_instr[i] <= '0;
        q_pred[i] <= '0;
      end
    end else begin
      if (acc) begin
        ifq[ifq_wr] <= fetch_pc;
        ifq_wr <= ifq_wr + 1'b1;
      end
      if (imem_rsp_valid) ifq_rd <= ifq_rd + 1'b1;
      outstanding <= out_next;
      if (enq) begin
        q_pc[q_tl] <= pred_pc;
        q_instr[q_tl] <= imem_rsp_data;
        q_pred[q_tl] <= pre_pc;
        q_tl <= q_tl + 1'b1;
      end
      if (q_deq) q_hd <= q_hd + 1'b1;
      qcount <= redirect_valid ? '0 : qcount + CW'(enq) - CW'(q_deq);
      // everything still in flight after a redirect or taken steer is on the wrong path
      if (redirect_valid) begin
        q_hd <= '0;
        q_tl <= '0;
        fetch_pc <= redirect_pc & ~32'h3;
        drop_cnt <= out_next;
      end else if (taken) begin
        fetch_pc <= pre_pc;
        drop_cnt <= out_next;
      end else begin
        if (acc) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: random memory/decode/redirect stimulus against an architectural fetch-path scoreboard.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int QDEPTH = 2;
  logic clk = 1'b0;
  logic reset, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, pred_instr, pred_pc, pre_pc, redirect_pc;
  logic [31:0] id_instr, id_pc, id_pred_pc;
  typedef struct {logic [31:0] a; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins; logic [31:0] pp;} exp_t;
  pend_t pend[$];
  exp_t exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] path_pc;
  int cyc, last_due, first_acc, max_lat, xfers, vectors, miscompares;
  bit chk_first;
  always #5 clk = ~clk;
  if_fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pred_instr(pred_instr), .pred_pc(pred_pc), .pre_pc(pre_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pred_pc(id_pred_pc)
  );
  // static predictor: JAL always taken, backward branches taken
  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] imm;
    imm = {{20{ins[31]}}, ins[31:20]};
    if (ins[6:0] == 7'h6F) return pc + imm;
    if (ins[6:0] == 7'h63 && ins[31]) return pc + imm;
    return pc + 32'd4;
  endfunction
  assign pre_pc = predict(pred_pc, pred_instr);
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int r;
    logic [11:0] off;
    if (!mem.exists(a)) begin
      r = int'($urandom_range(0, 99));
      off = 12'((int'($urandom_range(0, 63)) - 32) * 4);
      mem[a] = r < 70 ? 32'h13 : {off, 13'h0, r < 85 ? 7'h6F : 7'h63};
    end
    return mem[a];
  endfunction
  task automatic extend();
    logic [31:0] ins;
    while (exp_q.size() < 32) begin
      ins = mem_word(path_pc);
      exp_q.push_back('{path_pc, ins, predict(path_pc, ins)});
      path_pc = predict(path_pc, ins);
    end
  endtask
  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    path_pc = start;
    extend();
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic step(input bit rdy, input bit idr, input bit rdr, input logic [31:0] rpc);
    int due;
    @(negedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(pend[0].a);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    imem_req_ready = rdy;
    id_ready = idr;
    redirect_valid = rdr;
    redirect_pc = rpc;
    #1;
    if (chk_first && first_acc >= 0 && cyc == first_acc + 2) begin
      chk("first_id_valid", 32'(id_valid), 32'd1);
      chk("first_id_pc", id_pc, RESET_PC);
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(1, max_lat));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{imem_req_addr, due});
      chk("credit_bound", 32'(pend.size() <= QDEPTH), 32'd1);
      if (first_acc < 0) first_acc = cyc;
    end
    #2;
    if (rdr) restart(rpc & ~32'h3);
  endtask
  task automatic mid_reset();
    #1 reset = 1'b1;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_rst_id_valid", 32'(id_valid), 32'd0);
    pend.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    chk("post_rst_addr", imem_req_addr, RESET_PC);
    restart(RESET_PC);
    last_due = cyc;
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!reset && id_valid && id_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL id_underflow: got pc %h with no expected entry", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", id_instr, e.ins);
        chk("id_pred_pc", id_pred_pc, e.pp);
        extend();
      end
    end
  end
  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    vectors = 0;
    miscompares = 0;
    xfers = 0;
    mem[32'h0] = 32'h13;
    mem[32'h4] = 32'h13;
    mem[32'h8] = {12'h100, 13'h0, 7'h6F};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_pred_pc", pred_pc, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    reset = 1'b0;
    restart(RESET_PC);
    cyc = 0;
    last_due = 0;
    first_acc = -1;
    max_lat = 1;
    chk_first = 1'b1;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'd0);
    chk_first = 1'b0;
    max_lat = 3;
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_id_valid", 32'(id_valid), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h203);
    chk("redir_no_req", 32'(imem_req_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("redir_addr", imem_req_addr, 32'h200);
    chk("redir_flush", 32'(id_valid), 32'd0);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           32'($urandom_range(0, 1023)));
      if (n % 1000 == 999) mid_reset();
    end
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("progress", 32'(xfers > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
